// File: rtl/pipeline_ctrl_unit_pkg.sv
// pipeline_ctrl_unit_pkg: shared state encoding and default trap vector for the pipeline controller
package pipeline_ctrl_unit_pkg;
    typedef enum logic [1:0] {PC_RUN, PC_DRAIN, PC_TRAP, PC_HALT} pipe_ctrl_state_t;
    localparam logic [31:0] TRAP_VECTOR_DEFAULT = 32'h0000_0100;
endpackage

// File: rtl/pipeline_ctrl_unit_sat_counter.sv
// sat_counter: event counter that sticks at all-ones instead of wrapping
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);
    logic [W-1:0] cnt_q, cnt_d;
    always_comb cnt_d = (inc_i && !(&cnt_q)) ? cnt_q + W'(1) : cnt_q;
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end
    assign cnt_o = cnt_q;
endmodule

// File: rtl/pipeline_ctrl_unit.sv
// pipeline_ctrl_unit: stall/flush priority decoder with precise-exception drain, trap redirect and halt mode
module pipeline_ctrl_unit
    import pipeline_ctrl_unit_pkg::*;
#(
    parameter int          NUM_PREGS     = 4,
    parameter int          EX_PREG       = 1,
    parameter int          CNT_WIDTH     = 32,
    parameter int          DRAIN_TIMEOUT = 16,
    parameter logic [31:0] TRAP_VECTOR   = TRAP_VECTOR_DEFAULT
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 hazard_i,
    input  logic                 branch_flush_i,
    input  logic                 muldiv_ready_i,
    input  logic                 exception_i,
    input  logic                 halt_req_i,
    input  logic [NUM_PREGS-1:0] preg_valid_i,
    output logic                 pc_stall_o,
    output logic                 pc_flush_o,
    output logic [NUM_PREGS-1:0] preg_stall_o,
    output logic [NUM_PREGS-1:0] preg_flush_o,
    output logic                 trap_valid_o,
    output logic [31:0]          trap_pc_o,
    output logic                 trap_timeout_o,
    output logic [CNT_WIDTH-1:0] stall_cnt_o,
    output logic [CNT_WIDTH-1:0] flush_cnt_o,
    output logic [CNT_WIDTH-1:0] exc_cnt_o
);
    localparam int TW = $clog2(DRAIN_TIMEOUT + 1);

    pipe_ctrl_state_t state_q, state_d;
    logic [TW-1:0] timer_q;
    logic trap_timeout_q;
    logic [NUM_PREGS-1:0] m_le_ex, m_lt_ex, m_eq_ex, m_ex1, m_hold, m_last, m_older;
    logic [NUM_PREGS-1:0] stall, flush;
    logic drain_empty, drain_timeout;

    always_comb begin
        m_le_ex = '0;
        m_lt_ex = '0;
        m_eq_ex = '0;
        m_ex1   = '0;
        m_hold  = '0;
        m_last  = '0;
        m_older = '0;
        for (int i = 0; i < NUM_PREGS; i++) begin
            m_le_ex[i] = (i <= EX_PREG);
            m_lt_ex[i] = (i < EX_PREG);
            m_eq_ex[i] = (i == EX_PREG);
            m_ex1[i]   = (i == EX_PREG + 1);
            m_hold[i]  = (i <= NUM_PREGS - 2);
            m_last[i]  = (i == NUM_PREGS - 1);
            m_older[i] = (i >= EX_PREG + 2);
        end
    end

    assign drain_empty   = ~|(preg_valid_i & m_older);
    assign drain_timeout = timer_q == TW'(DRAIN_TIMEOUT - 1);

    // HALT only holds while requested and no exception; otherwise the RUN priority chain decides
    always_comb begin
        state_d      = state_q;
        pc_stall_o   = 1'b0;
        pc_flush_o   = 1'b0;
        trap_valid_o = 1'b0;
        stall        = '0;
        flush        = '0;
        if (reset_i) begin
            flush = '1;
        end else if (state_q == PC_TRAP) begin
            trap_valid_o = 1'b1;
            pc_flush_o   = 1'b1;
            flush        = '1;
            state_d      = PC_RUN;
        end else if (state_q == PC_DRAIN) begin
            pc_stall_o = 1'b1;
            stall      = m_le_ex;
            flush      = m_ex1;
            state_d    = (drain_empty || drain_timeout) ? PC_TRAP : PC_DRAIN;
        end else if (state_q == PC_HALT && halt_req_i && !exception_i) begin
            pc_stall_o = 1'b1;
            stall      = m_hold;
            flush      = m_last;
        end else if (exception_i) begin
            pc_stall_o = 1'b1;
            stall      = m_le_ex;
            flush      = m_ex1;
            state_d    = PC_DRAIN;
        end else if (branch_flush_i) begin
            pc_flush_o = 1'b1;
            flush      = m_le_ex;
            state_d    = PC_RUN;
        end else if (hazard_i) begin
            pc_stall_o = 1'b1;
            stall      = m_lt_ex;
            flush      = m_eq_ex;
            state_d    = PC_RUN;
        end else if (!muldiv_ready_i) begin
            pc_stall_o = 1'b1;
            stall      = m_le_ex;
            flush      = m_ex1;
            state_d    = PC_RUN;
        end else if (halt_req_i) begin
            pc_stall_o = 1'b1;
            stall      = m_hold;
            flush      = m_last;
            state_d    = PC_HALT;
        end else begin
            state_d = PC_RUN;
        end
    end

    assign preg_stall_o   = stall & ~flush;
    assign preg_flush_o   = flush;
    assign trap_pc_o      = trap_valid_o ? TRAP_VECTOR : '0;
    assign trap_timeout_o = trap_timeout_q;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q        <= PC_RUN;
            timer_q        <= '0;
            trap_timeout_q <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= (state_q == PC_DRAIN) ? timer_q + TW'(1) : '0;
            if (state_q == PC_DRAIN && state_d == PC_TRAP) trap_timeout_q <= drain_timeout;
        end
    end

    sat_counter #(.W(CNT_WIDTH)) u_stall_cnt (.clk_i(clk_i), .rst_i(reset_i), .inc_i(pc_stall_o),   .cnt_o(stall_cnt_o));
    sat_counter #(.W(CNT_WIDTH)) u_flush_cnt (.clk_i(clk_i), .rst_i(reset_i), .inc_i(pc_flush_o),   .cnt_o(flush_cnt_o));
    sat_counter #(.W(CNT_WIDTH)) u_exc_cnt   (.clk_i(clk_i), .rst_i(reset_i), .inc_i(trap_valid_o), .cnt_o(exc_cnt_o));
endmodule
